// File: rtl/cnn_layer_sequencer.sv
// rtl/cnn_layer_sequencer.sv - multi-layer descriptor scheduler for the convolution controller
// Runs up to MAX_LAYERS host-programmed layers, one start per layer, advancing on picture_finish falls.
module cnn_layer_sequencer #(
  parameter int MAX_LAYERS = 4,
  parameter int LW         = 2,
  parameter int AW         = 13,
  parameter int NF         = 13
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_we,
  input  logic [LW-1:0]    cfg_layer,
  input  logic [3:0]       cfg_field,
  input  logic [AW-1:0]    cfg_data,
  input  logic [LW:0]      num_layers,
  input  logic             cnn_start,
  input  logic             abort,
  input  logic             picture_finish,
  output logic             start,
  output logic [NF*AW-1:0] layer_cfg,
  output logic [LW-1:0]    cur_layer,
  output logic             busy,
  output logic             cnn_finish,
  output logic [2:0]       cnn_state
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CFG   = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DONE  = 3'd4
  } state_t;

  localparam logic [LW:0] MAX_N = (LW+1)'(MAX_LAYERS);

  state_t            state, state_nxt;
  logic              picture_finish_d;
  logic              fall;
  logic [LW:0]       n_reg;
  logic [AW-1:0]     tbl [MAX_LAYERS][NF];
  logic              wr_en;
  logic              last;
  logic [LW-1:0]     load_idx;
  logic [NF*AW-1:0]  entry;

  assign fall  = picture_finish_d & ~picture_finish;
  assign wr_en = (state == IDLE) && cfg_we && (cfg_field < 4'(NF)) &&
                 ({1'b0, cfg_layer} < MAX_N);
  assign last  = ({1'b0, cur_layer} == (n_reg - 1'b1));

  // The next CFG always loads layer 0 from IDLE, otherwise the following layer.
  assign load_idx = (state == IDLE) ? '0 : cur_layer + 1'b1;

  // A write landing in the same IDLE cycle as cnn_start is forwarded into the first load.
  always_comb begin
    entry = '0;
    for (int f = 0; f < NF; f++) begin
      if (wr_en && (cfg_layer == load_idx) && (cfg_field == 4'(f)))
        entry[f*AW +: AW] = cfg_data;
      else
        entry[f*AW +: AW] = tbl[load_idx][f];
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (cnn_start)
          state_nxt = (num_layers == '0) ? DONE : CFG;
      end
      CFG:   state_nxt = START;
      START: state_nxt = RUN;
      RUN: begin
        if (fall)
          state_nxt = last ? DONE : CFG;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (abort && (state != IDLE))
      state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= IDLE;
      picture_finish_d <= 1'b0;
      n_reg            <= '0;
      layer_cfg        <= '0;
      cur_layer        <= '0;
    end else begin
      state            <= state_nxt;
      picture_finish_d <= picture_finish;
      if ((state == IDLE) && cnn_start)
        n_reg <= (num_layers > MAX_N) ? MAX_N : num_layers;
      if (state_nxt == CFG) begin
        layer_cfg <= entry;
        cur_layer <= load_idx;
      end else if (state_nxt == IDLE) begin
        layer_cfg <= '0;
        cur_layer <= '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int l = 0; l < MAX_LAYERS; l++)
        for (int f = 0; f < NF; f++)
          tbl[l][f] <= '0;
    end else begin
      for (int l = 0; l < MAX_LAYERS; l++)
        for (int f = 0; f < NF; f++)
          if (wr_en && (cfg_layer == LW'(l)) && (cfg_field == 4'(f)))
            tbl[l][f] <= cfg_data;
    end
  end

  assign start      = (state == START);
  assign cnn_finish = (state == DONE);
  assign busy       = (state != IDLE);
  assign cnn_state  = state;

endmodule

// File: tb/tb_cnn_layer_sequencer.sv
// tb/tb_cnn_layer_sequencer.sv - scoreboard bench for cnn_layer_sequencer
module tb_cnn_layer_sequencer;

  localparam int CW = 169;

  typedef struct packed {
    logic          fin;
    logic [1:0]    layer;
    logic [CW-1:0] cfg;
  } ev_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          cfg_we;
  logic [1:0]    cfg_layer;
  logic [3:0]    cfg_field;
  logic [12:0]   cfg_data;
  logic [2:0]    num_layers;
  logic          cnn_start;
  logic          abort;
  logic          picture_finish;
  logic          start;
  logic [CW-1:0] layer_cfg;
  logic [1:0]    cur_layer;
  logic          busy;
  logic          cnn_finish;
  logic [2:0]    cnn_state;

  int total = 0;
  int bad   = 0;

  ev_t exp_q[$];
  ev_t obs_q[$];
  logic [12:0] mdl [4][13];

  cnn_layer_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_layer(cfg_layer),
    .cfg_field(cfg_field), .cfg_data(cfg_data), .num_layers(num_layers),
    .cnn_start(cnn_start), .abort(abort), .picture_finish(picture_finish),
    .start(start), .layer_cfg(layer_cfg), .cur_layer(cur_layer), .busy(busy),
    .cnn_finish(cnn_finish), .cnn_state(cnn_state)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start)      obs_q.push_back('{1'b0, cur_layer, layer_cfg});
    if (cnn_finish) obs_q.push_back('{1'b1, 2'd0, {CW{1'b0}}});
  end

  task automatic chk(input string tag, input logic [CW-1:0] obs, input logic [CW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [CW-1:0] pack(input int l);
    logic [CW-1:0] v = '0;
    for (int f = 0; f < 13; f++) v[f*13 +: 13] = mdl[l][f];
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int l, input int f, input int d);
    cfg_we = 1'b1; cfg_layer = l[1:0]; cfg_field = f[3:0]; cfg_data = d[12:0];
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic drain();
    ev_t e, o;
    while (exp_q.size() > 0 && obs_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      chk("sb_kind", o.fin, e.fin);
      chk("sb_layer", o.layer, e.layer);
      chk("sb_cfg", o.cfg, e.cfg);
    end
    chk("sb_leftover", obs_q.size() + exp_q.size(), 0);
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic check_idle();
    chk("idle_state", cnn_state, 0);
    chk("idle_busy", busy, 0);
    chk("idle_cur", cur_layer, 0);
    chk("idle_cfg", layer_cfg, 0);
  endtask

  task automatic run(input int n, input bit wr_same);
    int ne = (n > 4) ? 4 : n;
    num_layers = n[2:0];
    cnn_start  = 1'b1;
    if (wr_same) begin
      cfg_we = 1'b1; cfg_layer = 2'd0; cfg_field = 4'd0; cfg_data = 13'd77;
      mdl[0][0] = 13'd77;
    end
    tick();
    cnn_start = 1'b0;
    cfg_we    = 1'b0;
    for (int i = 0; i < ne; i++) begin
      chk("cfg_state", cnn_state, 1);
      chk("cfg_cur", cur_layer, i);
      chk("cfg_value", layer_cfg, pack(i));
      exp_q.push_back('{1'b0, i[1:0], pack(i)});
      tick();
      chk("start_high", start, 1);
      tick();
      chk("run_state", cnn_state, 3);
      wr(i, 2, 99);
      tick();
      picture_finish = 1'b0;
      tick();
      picture_finish = 1'b1;
    end
    chk("done_state", cnn_state, 4);
    chk("done_finish", cnn_finish, 1);
    chk("done_start", start, 0);
    exp_q.push_back('{1'b1, 2'd0, {CW{1'b0}}});
    tick();
    chk("after_finish", cnn_finish, 0);
    check_idle();
    drain();
  endtask

  int l0 [13] = '{4, 1, 28, 28, 4, 4, 4, 4, 13, 13, 1, 805, 1000};
  int l1 [13] = '{4, 4, 13, 13, 5, 5, 5, 4, 5, 5, 1000, 2000, 3000};

  initial begin
    rst = 1'b0; cfg_we = 1'b0; cfg_layer = '0; cfg_field = '0; cfg_data = '0;
    num_layers = '0; cnn_start = 1'b0; abort = 1'b0; picture_finish = 1'b1;
    for (int l = 0; l < 4; l++) for (int f = 0; f < 13; f++) mdl[l][f] = '0;
    tick(); tick();
    check_idle();
    chk("rst_start", start, 0);
    chk("rst_finish", cnn_finish, 0);
    rst = 1'b1;
    tick();

    for (int f = 0; f < 13; f++) begin
      wr(0, f, l0[f]); mdl[0][f] = l0[f][12:0];
      wr(1, f, l1[f]); mdl[1][f] = l1[f][12:0];
    end
    wr(2, 13, 55);
    wr(3, 15, 66);

    run(2, 1'b0);
    run(2, 1'b0);
    chk("dr_kept", layer_cfg, 0);
    chk("dr_model", mdl[1][2], 13);
    run(0, 1'b0);

    // abort during layer 0
    num_layers = 3'd2; cnn_start = 1'b1;
    tick();
    cnn_start = 1'b0;
    exp_q.push_back('{1'b0, 2'd0, pack(0)});
    tick(); tick();
    chk("abort_pre", cnn_state, 3);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check_idle();
    chk("abort_finish", cnn_finish, 0);
    picture_finish = 1'b0;
    tick(); tick();
    picture_finish = 1'b1;
    tick();
    check_idle();
    drain();

    // falls in IDLE and CFG are ignored
    picture_finish = 1'b0;
    tick();
    picture_finish = 1'b1;
    tick();
    check_idle();
    tick();
    num_layers = 3'd2; cnn_start = 1'b1;
    tick();
    cnn_start = 1'b0;
    exp_q.push_back('{1'b0, 2'd0, pack(0)});
    picture_finish = 1'b0;
    tick();
    chk("cfg_fall_state", cnn_state, 2);
    chk("cfg_fall_cur", cur_layer, 0);
    picture_finish = 1'b1;
    tick(); tick();
    picture_finish = 1'b0;
    tick();
    picture_finish = 1'b1;
    chk("adv_state", cnn_state, 1);
    chk("adv_cur", cur_layer, 1);
    exp_q.push_back('{1'b0, 2'd1, pack(1)});
    tick(); tick(); tick();
    picture_finish = 1'b0;
    tick();
    picture_finish = 1'b1;
    chk("adv_done", cnn_state, 4);
    exp_q.push_back('{1'b1, 2'd0, {CW{1'b0}}});
    tick();
    check_idle();
    drain();

    run(7, 1'b0);
    run(1, 1'b1);

    // asynchronous reset mid-run clears outputs and table
    num_layers = 3'd1; cnn_start = 1'b1;
    tick();
    cnn_start = 1'b0;
    exp_q.push_back('{1'b0, 2'd0, pack(0)});
    tick(); tick();
    chk("rst_run", cnn_state, 3);
    #2;
    rst = 1'b0;
    #1;
    check_idle();
    chk("arst_start", start, 0);
    chk("arst_finish", cnn_finish, 0);
    drain();
    for (int l = 0; l < 4; l++) for (int f = 0; f < 13; f++) mdl[l][f] = '0;
    tick();
    rst = 1'b1;
    tick();
    run(1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
